uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx.sv | 111 +++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
// State encoding and frame sizing used by tx and rx paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  function automatic int frame_bits(
    input int data_bits,
    input int parity_en
  );
    return data_bits + parity_en + 2;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter with enable and synchronous clear.
// bit_tick pulses on the last cycle of each bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, LSB first, optional even parity.
// Line level is registered; polarity inversion is folded into the flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int TX_INVERT    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic INV = (TX_INVERT != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  state_e               state;
  state_e               state_nx;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 par_q;
  logic                 tx_q;
  logic                 line_nx;
  logic                 accept;
  logic                 bit_tick;

  assign tx_ready = rst_n && (state == ST_IDLE);
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state != ST_IDLE);
  assign tx       = tx_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .en      (busy),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (accept) state_nx = ST_START;
      ST_START:  if (bit_tick) state_nx = ST_DATA;
      ST_DATA: begin
        if (bit_tick && bit_cnt == LAST_BIT) begin
          state_nx = HAS_PAR ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (bit_tick) state_nx = ST_STOP;
      ST_STOP:   if (bit_tick) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Logical level for the next cycle; holds unless a bit boundary hits.
  always_comb begin
    line_nx = tx_q ^ INV;
    if (accept) begin
      line_nx = 1'b0;
    end else if (bit_tick) begin
      unique case (state_nx)
        ST_DATA:   line_nx = shreg[0];
        ST_PARITY: line_nx = par_q;
        default:   line_nx = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q    <= 1'b1 ^ INV;
      shreg   <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
    end else begin
      tx_q <= line_nx ^ INV;
      if (accept) begin
        shreg   <= tx_data;
        par_q   <= ^tx_data;
        bit_cnt <= '0;
      end else if (bit_tick) begin
        if (state_nx == ST_DATA) begin
          shreg <= shreg >> 1;
        end
        if (state == ST_DATA) begin
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: 8N1, even-parity and inverted-line instances.
// Table-driven frames plus back-to-back and mid-frame reset sequences.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] txl;
  logic [2:0] busy;
  logic [7:0] dat [3];

  int tests;
  int fails;

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic [10:0] exp;
    int         nb;
    logic       idle;
    string      nm;
  } vec_t;

  vec_t vt [4];

  uart_tx #(.CLKS_PER_BIT(4)) u_plain (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx(txl[0]), .busy(busy[0])
  );

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx(txl[1]), .busy(busy[1])
  );

  uart_tx #(.CLKS_PER_BIT(4), .TX_INVERT(1)) u_inv (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx(txl[2]), .busy(busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input int s, input logic [7:0] d,
                           input logic [10:0] exp, input int nb,
                           input logic idle, input string nm);
    int n;
    int errs;
    int bc;
    logic inv;
    logic w;
    logic [7:0] got;
    n = 0;
    errs = 0;
    bc = 0;
    got = '0;
    inv = ~idle;
    @(negedge clk);
    while (!ready[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_rdy"}, 32'(ready[s]), 32'd1);
    dat[s] = d;
    valid[s] = 1'b1;
    @(posedge clk);
    #1;
    valid[s] = 1'b0;
    dat[s] = ~d;
    for (int k = 0; k < nb * 4; k++) begin
      @(negedge clk);
      w = txl[s];
      if (w !== (exp[k / 4] ^ inv)) errs++;
      if (ready[s] !== 1'b0) errs++;
      if (busy[s] === 1'b1) bc++;
      if ((k % 4) == 2 && (k / 4) >= 1 && (k / 4) <= 8) begin
        got[(k / 4) - 1] = w ^ inv;
      end
    end
    chk({nm, "_wave"}, 32'(errs), 32'd0);
    chk({nm, "_len"}, 32'(bc), 32'(nb * 4));
    chk({nm, "_rx"}, 32'(got), 32'(d));
    @(negedge clk);
    chk({nm, "_done"}, {29'd0, txl[s], ready[s], busy[s]},
        {29'd0, idle, 1'b1, 1'b0});
  endtask

  initial begin
    logic [80:0] wv;
    logic [10:0] f00;
    logic [10:0] fff;
    logic [7:0] g0;
    logic [7:0] g1;
    logic r40;
    logic e;
    int errs;
    int bc;

    tests = 0;
    fails = 0;
    vt[0] = '{0, 8'hA5, 11'b01101001010, 10, 1'b1, "a5_8n1"};
    vt[1] = '{1, 8'h03, 11'b10000000110, 11, 1'b1, "p03"};
    vt[2] = '{1, 8'h07, 11'b11000001110, 11, 1'b1, "p07"};
    vt[3] = '{2, 8'h55, 11'b01010101010, 10, 1'b0, "inv55"};

    rst_n = 1'b0;
    valid = 3'b001;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;

    // Reset held with a pending byte
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(txl[0]), 32'd1);
    chk("rst_tx_inv", 32'(txl[2]), 32'd0);
    chk("rst_ready", 32'(ready[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    rst_n = 1'b1;
    valid[0] = 1'b0;
    bc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy[0] !== 1'b0 || txl[0] !== 1'b1) bc++;
    end
    chk("rel_idle", 32'(bc), 32'd0);
    chk("rel_ready", 32'(ready[0]), 32'd1);

    for (int i = 0; i < 4; i++) begin
      run_frame(vt[i].sel, vt[i].d, vt[i].exp, vt[i].nb,
                vt[i].idle, vt[i].nm);
    end

    // Back-to-back 0x00 then 0xFF with valid held high
    f00 = 11'b01000000000;
    fff = 11'b01111111110;
    @(negedge clk);
    dat[0] = 8'h00;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    dat[0] = 8'hFF;
    r40 = 1'b0;
    wv = '0;
    for (int k = 0; k < 81; k++) begin
      @(negedge clk);
      wv[k] = txl[0];
      if (k == 40) r40 = ready[0];
      if (k == 41) valid[0] = 1'b0;
    end
    errs = 0;
    for (int k = 0; k < 81; k++) begin
      if (k < 40) e = f00[k / 4];
      else if (k == 40) e = 1'b1;
      else e = fff[(k - 41) / 4];
      if (wv[k] !== e) errs++;
    end
    for (int i = 0; i < 8; i++) begin
      g0[i] = wv[(1 + i) * 4 + 2];
      g1[i] = wv[41 + (1 + i) * 4 + 2];
    end
    chk("b2b_wave", 32'(errs), 32'd0);
    chk("b2b_gap_ready", 32'(r40), 32'd1);
    chk("b2b_start2", 32'(wv[41]), 32'd0);
    chk("b2b_rx0", 32'(g0), 32'h00);
    chk("b2b_rx1", 32'(g1), 32'hFF);
    @(negedge clk);
    chk("b2b_done", {30'd0, ready[0], busy[0]}, {30'd0, 1'b1, 1'b0});

    // Reset in the middle of a 0x3C frame
    @(negedge clk);
    dat[0] = 8'h3C;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_line", 32'(txl[0]), 32'd0);
    chk("mid_busy", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_tx", 32'(txl[0]), 32'd1);
    chk("mr_busy", 32'(busy[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rel", {29'd0, txl[0], ready[0], busy[0]},
        {29'd0, 1'b1, 1'b1, 1'b0});
    run_frame(0, 8'h81, 11'b01100000010, 10, 1'b1, "post81");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
